// File: rtl/smi_rx_arbiter.sv
// Purpose: shares one RX FIFO write port between two sample channels; round-robin grants in bursts of up to BURST_LEN words.
// Latency: strobe to hold register 1 cycle; push in the next cycle if the channel is granted, one more cycle from IDLE.
// Backpressure: i_fifo_full stalls the current grant in place; a word arriving at a full, unconsumed hold is dropped and counted.
module smi_rx_arbiter #(
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_b,
  input  logic [1:0]            i_en,
  input  logic                  i_ch0_valid,
  input  logic [31:0]           i_ch0_data,
  input  logic                  i_ch1_valid,
  input  logic [31:0]           i_ch1_data,
  output logic                  o_fifo_push,
  output logic [31:0]           o_fifo_data,
  input  logic                  i_fifo_full,
  output logic                  o_active_ch,
  output logic [DROP_CNT_W-1:0] o_drop_cnt0,
  output logic [DROP_CNT_W-1:0] o_drop_cnt1,
  input  logic                  i_drop_clr,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SERVE0 = 2'b01,
    ST_SERVE1 = 2'b10
  } state_e;

  // Burst counter value at which the next push completes the burst.
  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  state_e                state_q, state_d;
  logic                  active_q, active_d;
  logic [7:0]            burst_q, burst_d;
  logic [1:0]            hold_v_q, hold_v_d;
  logic [31:0]           hold_dat0_q, hold_dat1_q;
  logic [DROP_CNT_W-1:0] drop_cnt0_q, drop_cnt1_q;

  logic push0, push1, ld0, ld1, drop0, drop1;
  logic cur, push_cur, exit_srv, grant, grant_ch;

  // Push, load and drop decisions; a push frees the hold for a same-cycle load.
  always_comb begin
    push0 = (state_q == ST_SERVE0) & hold_v_q[0] & ~i_fifo_full;
    push1 = (state_q == ST_SERVE1) & hold_v_q[1] & ~i_fifo_full;
    ld0   = i_ch0_valid & i_en[0] & (~hold_v_q[0] | push0);
    ld1   = i_ch1_valid & i_en[1] & (~hold_v_q[1] | push1);
    drop0 = i_ch0_valid & i_en[0] & ~ld0;
    drop1 = i_ch1_valid & i_en[1] & ~ld1;
  end

  // Next hold-valid flags; a disabled channel empties its hold on the following edge.
  always_comb begin
    hold_v_d = hold_v_q;
    if (!i_en[0])   hold_v_d[0] = 1'b0;
    else if (ld0)   hold_v_d[0] = 1'b1;
    else if (push0) hold_v_d[0] = 1'b0;
    if (!i_en[1])   hold_v_d[1] = 1'b0;
    else if (ld1)   hold_v_d[1] = 1'b1;
    else if (push1) hold_v_d[1] = 1'b0;
  end

  // Grant FSM; exit decisions look at next-cycle hold state so a switch costs no idle cycle.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    burst_d  = burst_q;
    grant    = 1'b0;
    grant_ch = 1'b0;
    exit_srv = 1'b0;
    cur      = (state_q == ST_SERVE1);
    push_cur = push0 | push1;
    case (state_q)
      ST_IDLE: begin
        if (hold_v_q == 2'b11) begin
          grant    = 1'b1;
          grant_ch = ~active_q;
        end else if (hold_v_q[0]) begin
          grant    = 1'b1;
          grant_ch = 1'b0;
        end else if (hold_v_q[1]) begin
          grant    = 1'b1;
          grant_ch = 1'b1;
        end
      end
      ST_SERVE0, ST_SERVE1: begin
        exit_srv = (push_cur && (burst_q == BURST_LAST)) ||
                   (!hold_v_q[cur] && hold_v_q[!cur]) ||
                   !i_en[cur];
        if (exit_srv) begin
          if (hold_v_d[!cur]) begin
            grant    = 1'b1;
            grant_ch = !cur;
          end else if (hold_v_d[cur]) begin
            grant    = 1'b1;
            grant_ch = cur;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (push_cur) begin
          burst_d = burst_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant) begin
      state_d  = grant_ch ? ST_SERVE1 : ST_SERVE0;
      active_d = grant_ch;
      burst_d  = '0;
    end
  end

  // FSM, round-robin pointer and burst counter registers.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b1;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      burst_q  <= burst_d;
    end
  end

  // Per-channel holding registers.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      hold_v_q    <= '0;
      hold_dat0_q <= '0;
      hold_dat1_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      if (ld0) hold_dat0_q <= i_ch0_data;
      if (ld1) hold_dat1_q <= i_ch1_data;
    end
  end

  // Saturating drop counters; clear takes priority over an increment.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      drop_cnt0_q <= '0;
      drop_cnt1_q <= '0;
    end else if (i_drop_clr) begin
      drop_cnt0_q <= '0;
      drop_cnt1_q <= '0;
    end else begin
      if (drop0 && !(&drop_cnt0_q)) drop_cnt0_q <= drop_cnt0_q + 1'b1;
      if (drop1 && !(&drop_cnt1_q)) drop_cnt1_q <= drop_cnt1_q + 1'b1;
    end
  end

  // FIFO write data follows the granted channel's hold; zero when idle.
  always_comb begin
    o_fifo_data = '0;
    case (state_q)
      ST_SERVE0: o_fifo_data = hold_dat0_q;
      ST_SERVE1: o_fifo_data = hold_dat1_q;
      default:   o_fifo_data = '0;
    endcase
  end

  assign o_fifo_push = push0 | push1;
  assign o_active_ch = active_q;
  assign o_drop_cnt0 = drop_cnt0_q;
  assign o_drop_cnt1 = drop_cnt1_q;
  assign o_state     = state_q;

endmodule
